// File: rtl/pdm_demod.sv
// pdm_demod: 2nd-order CIC PDM-to-PCM decimator with valid/ready output and sticky overrun.
// Define PDM_DEMOD_SYNC_EN to add a two-flop synchronizer on pdm_in.
module pdm_demod #(
   parameter int VALUE_BITS = 8,
   parameter int LOG2_R     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_en,
   input  logic                  pdm_in,
   output logic [VALUE_BITS-1:0] value,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun,
   input  logic                  clr_overrun
);
   localparam int W = 2*LOG2_R+1;
   typedef enum logic [1:0] {WARMUP0, WARMUP1, RUN} state_t;
   state_t                r_state, w_state_nxt;
   logic                  w_din, w_dec, w_new_ovr, r_load;
   logic [W-1:0]          r_i1, r_i2, r_i2d, r_c1d, w_c1, w_y;
   logic [W-2:0]          w_sat;
   logic [LOG2_R-1:0]     r_cnt;
   logic [VALUE_BITS-1:0] r_word;

`ifdef PDM_DEMOD_SYNC_EN
   logic [1:0] r_sync;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_sync <= '0;
      else r_sync <= {r_sync[0], pdm_in};
   assign w_din = r_sync[1];
`else
   assign w_din = pdm_in;
`endif

   assign w_dec     = sample_en && (&r_cnt);
   assign w_c1      = r_i2 - w_zero_guard(r_i2d);
   assign w_y       = w_c1 - r_c1d;
   // Only R^2 can overflow the 2*LOG2_R-bit range; clamp it to full scale.
   assign w_sat     = w_y[W-1] ? '1 : w_y[W-2:0];
   assign w_new_ovr = r_load && out_valid && !out_ready;

   function automatic logic [W-1:0] w_zero_guard(input logic [W-1:0] x);
      return x;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      if (w_dec) w_state_nxt = (r_state == WARMUP0) ? WARMUP1 : RUN;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= WARMUP0;
      else r_state <= w_state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i1   <= '0;
         r_i2   <= '0;
         r_i2d  <= '0;
         r_c1d  <= '0;
         r_cnt  <= '0;
         r_word <= '0;
         r_load <= 1'b0;
      end else begin
         if (sample_en) begin
            r_i1  <= r_i1 + W'(w_din);
            r_i2  <= r_i2 + r_i1;
            r_cnt <= r_cnt + LOG2_R'(1);
         end
         if (w_dec) begin
            r_i2d  <= r_i2;
            r_c1d  <= w_c1;
            r_word <= w_sat[W-2 -: VALUE_BITS];
         end
         r_load <= w_dec && (r_state == RUN);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (r_load) begin
            value     <= r_word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         overrun <= (overrun && !clr_overrun) || w_new_ovr;
      end
   end
endmodule

// File: tb/tb_pdm_demod.sv
// tb_pdm_demod: vector table, corner sequences and random traffic against a
// triangle-weighted CIC reference model of pdm_demod.
module tb_pdm_demod;
   localparam int L = 4, VB = 8, R = 1 << L;
   logic clk = 0, rst_n = 1, sample_en = 0, pdm_in = 0, out_ready = 0, clr_overrun = 0;
   logic [VB-1:0] value;
   logic out_valid, overrun;
   int checks = 0, errors = 0;
   bit s[$];
   int m_value, m_pend_w, sd_acc;
   bit m_valid, m_ovr, m_pend;

   typedef struct {int mode; int arg; int lo; int hi;} vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   pdm_demod dut (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .pdm_in(pdm_in),
      .value(value), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   // Second integrator seen at decimation event k: each bit weighted by how many
   // later samples it has been accumulated through.
   function automatic longint g(int k);
      int n = k*R - 1;
      longint acc = 0;
      for (int j = 0; j < n; j++) if (s[j]) acc += n - 1 - j;
      return acc;
   endfunction

   function automatic int word(int k);
      longint y = g(k) - 2*g(k-1) + g(k-2);
      if (y > (1 << 2*L) - 1) y = (1 << 2*L) - 1;
      return int'(y >> (2*L - VB));
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      bit ld = m_pend, new_ovr;
      int w = m_pend_w;
      m_pend = 0;
      if (sample_en) begin
         s.push_back(pdm_in);
         if (s.size() % R == 0 && s.size() / R >= 3) begin
            m_pend = 1;
            m_pend_w = word(s.size() / R);
         end
      end
      new_ovr = ld && m_valid && !out_ready;
      if (ld) begin
         m_value = w;
         m_valid = 1;
      end else if (m_valid && out_ready) m_valid = 0;
      m_ovr = (m_ovr && !clr_overrun) || new_ovr;
      @(posedge clk); #1;
      check("value", value, m_value);
      check("out_valid", out_valid, m_valid);
      check("overrun", overrun, m_ovr);
   endtask

   task automatic do_reset();
      rst_n = 0;
      #2;
      check("rst_value", value, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_overrun", overrun, 0);
      @(posedge clk); #1;
      rst_n = 1;
      s.delete();
      m_value = 0; m_valid = 0; m_ovr = 0; m_pend = 0;
   endtask

   initial begin
      int first, pulses;
      vecs[0] = '{0, 0, 0, 0};
      vecs[1] = '{0, 1, 255, 255};
      vecs[2] = '{1, 0, 128, 128};
      vecs[3] = '{2, 64, 63, 65};
      vecs[4] = '{2, 192, 191, 193};
      vecs[5] = '{2, 128, 127, 129};
      vecs[6] = '{3, 0, 64, 64};
      #1;
      foreach (vecs[i]) begin
         do_reset();
         sample_en = 1; out_ready = 1; sd_acc = 0; first = -1; pulses = 0;
         for (int t = 0; t < 12*R; t++) begin
            case (vecs[i].mode)
               0: pdm_in = (vecs[i].arg != 0);
               1: pdm_in = (t % 2 == 0);
               2: begin
                  sd_acc += vecs[i].arg;
                  pdm_in = (sd_acc >= 256);
                  sd_acc %= 256;
               end
               default: pdm_in = (t % 4 == 0);
            endcase
            tick();
            if (out_valid && first < 0) first = t + 1;
            if (out_valid && t >= 4*R) pulses++;
         end
         check($sformatf("first_valid_tick[%0d]", i), first, 3*R + 1);
         check($sformatf("pulses[%0d]", i), pulses, 8);
         checks++;
         if (value < vecs[i].lo || value > vecs[i].hi) begin
            errors++;
            $display("FAIL steady[%0d]: got %0d expected %0d..%0d", i, value, vecs[i].lo, vecs[i].hi);
         end
      end

      do_reset();
      sample_en = 1; out_ready = 1;
      for (int t = 0; t < 3*R + 2; t++) begin pdm_in = (t % 2 == 0); tick(); end
      out_ready = 0;
      for (int t = 0; t < 2*R; t++) begin pdm_in = ~pdm_in; tick(); end
      check("overrun_set", overrun, 1);
      clr_overrun = 1; pdm_in = ~pdm_in; tick(); clr_overrun = 0;
      check("overrun_clr", overrun, 0);
      for (int t = 0; t < 13; t++) begin pdm_in = ~pdm_in; tick(); end
      out_ready = 1; pdm_in = ~pdm_in; tick(); out_ready = 0;
      check("load_ready_ovr", overrun, 0);
      check("load_ready_valid", out_valid, 1);

      do_reset();
      sample_en = 1; out_ready = 1; pdm_in = 1;
      repeat (4*R + 7) tick();
      check("midframe_pos", s.size() % R, 7);
      do_reset();
      first = -1;
      for (int t = 0; t < 4*R; t++) begin
         tick();
         if (out_valid && first < 0) first = t + 1;
      end
      check("post_reset_first", first, 3*R + 1);
      check("post_reset_value", value, 255);

      do_reset();
      for (int t = 0; t < 3000; t++) begin
         sample_en = ($urandom_range(3) != 0);
         pdm_in = $urandom_range(1);
         out_ready = $urandom_range(1);
         clr_overrun = ($urandom_range(9) == 0);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
